// File: rtl/dda_timer.sv
`default_nettype none
// ============================================================================
// Module     : dda_timer
// Description: Step-pulse generator for one stepper axis. It consumes queued
//              move slots in order and runs a 64-bit DDA accumulator with
//              linear velocity ramping.
// Revision   : 1.0 - initial release
// ============================================================================
module dda_timer #(
    parameter int MOVE_BUFFER_BITS = 1,
    parameter int MOVE_BUFFER_SIZE = 3
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [7:0]                clock_divisor,
    input  logic [63:0]               move_duration,
    input  logic [63:0]               increment,
    input  logic [63:0]               incrementincrement,
    input  logic [MOVE_BUFFER_SIZE:0] stepready,
    output logic [MOVE_BUFFER_SIZE:0] stepfinished,
    output logic [MOVE_BUFFER_BITS:0] moveind,
    input  logic [MOVE_BUFFER_BITS:0] writemoveind,
    input  logic                      halt,
    output logic                      move_done,
    output logic                      step
);

    localparam logic [MOVE_BUFFER_BITS:0] IND_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                    state;
    logic [63:0]               acc;
    logic [63:0]               remaining;
    logic [63:0]               incinc_r;
    // One bit wider than the increment port: the loaded value is taken as an
    // unsigned rate, and ramping below zero is seen as a set top bit.
    logic [64:0]               inc_r;
    logic [7:0]                prescale;
    logic [7:0]                step_cnt;

    logic [7:0]                div_eff;
    logic [7:0]                step_width;
    logic [MOVE_BUFFER_SIZE:0] pending;
    logic [MOVE_BUFFER_BITS:0] next_ind;
    logic [64:0]               sum;
    logic                      tick;
    logic                      finish;

    always_comb begin
        div_eff    = (clock_divisor == 8'd0) ? 8'd1 : clock_divisor;
        step_width = (div_eff < 8'd2) ? 8'd1 : (div_eff >> 1);
        pending    = stepready ^ stepfinished;
        next_ind   = moveind + IND_ONE;
        sum        = {1'b0, acc} + {1'b0, inc_r[63:0]};
        tick       = (state == RUN) && (prescale >= div_eff - 8'd1);
        finish     = ((state == LOAD) && (move_duration == 64'd0)) ||
                     (tick && (remaining == 64'd1));
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stepfinished <= '0;
            moveind      <= '0;
            move_done    <= 1'b1;
            step         <= 1'b0;
            step_cnt     <= '0;
            acc          <= '0;
            inc_r        <= '0;
            incinc_r     <= '0;
            remaining    <= '0;
            prescale     <= '0;
        end else if (halt) begin
            stepfinished <= stepready;
            moveind      <= writemoveind;
            acc          <= '0;
            step         <= 1'b0;
            step_cnt     <= '0;
            state        <= IDLE;
            move_done    <= 1'b1;
        end else begin
            // The pulse runs out on its own, independent of the move state.
            if (step) begin
                if (step_cnt == 8'd0) begin
                    step <= 1'b0;
                end else begin
                    step_cnt <= step_cnt - 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (pending[moveind]) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    remaining <= move_duration;
                    inc_r     <= {1'b0, increment};
                    incinc_r  <= incrementincrement;
                    acc       <= '0;
                    prescale  <= '0;
                    if (move_duration != 64'd0) begin
                        move_done <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    prescale <= tick ? 8'd0 : prescale + 8'd1;
                    if (tick) begin
                        if (!inc_r[64]) begin
                            acc <= sum[63:0];
                            if (sum[64]) begin
                                step     <= 1'b1;
                                step_cnt <= step_width - 8'd1;
                            end
                        end
                        inc_r     <= inc_r + {incinc_r[63], incinc_r};
                        remaining <= remaining - 64'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (finish) begin
                stepfinished[moveind] <= ~stepfinished[moveind];
                moveind               <= next_ind;
                state                 <= IDLE;
                move_done             <= ~pending[next_ind];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dda_timer.sv
`default_nettype none
// ============================================================================
// Module     : tb_dda_timer
// Description: Directed self-checking bench for dda_timer with a per-cycle
//              reference timeline built from the move rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_dda_timer;

    localparam int DEPTH = 1024;
    localparam logic [63:0] HALF    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] QUARTER = 64'h4000_0000_0000_0000;
    localparam logic [63:0] SIXTEENTH = 64'h1000_0000_0000_0000;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  clock_divisor;
    logic [63:0] move_duration;
    logic [63:0] increment;
    logic [63:0] incrementincrement;
    logic [3:0]  stepready;
    logic [3:0]  stepfinished;
    logic [1:0]  moveind;
    logic [1:0]  writemoveind;
    logic        halt;
    logic        move_done;
    logic        step;

    dda_timer dut (
        .CLK                (CLK),
        .reset              (reset),
        .clock_divisor      (clock_divisor),
        .move_duration      (move_duration),
        .increment          (increment),
        .incrementincrement (incrementincrement),
        .stepready          (stepready),
        .stepfinished       (stepfinished),
        .moveind            (moveind),
        .writemoveind       (writemoveind),
        .halt               (halt),
        .move_done          (move_done),
        .step               (step)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected outputs as seen just after edge n.
    logic       exp_step [DEPTH];
    logic [3:0] exp_fin  [DEPTH];
    logic [1:0] exp_ind  [DEPTH];
    logic       exp_md   [DEPTH];

    logic [3:0] mdl_fin = '0;
    logic [1:0] mdl_ind = '0;
    bit         check_en = 1'b0;

    int total = 0;
    int bad   = 0;

    int rises = 0;
    int hi_cnt = 0;
    int rise_cyc = 0;
    int fin_chg_cyc = 0;
    logic prev_step = 1'b0;
    logic [3:0] prev_fin = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (step && !prev_step) begin
            rises++;
            rise_cyc = cyc;
        end
        if (step) hi_cnt++;
        if (stepfinished !== prev_fin) fin_chg_cyc = cyc;
        prev_step = step;
        prev_fin  = stepfinished;
        if (check_en) begin
            if (cyc >= DEPTH) begin
                chk("cycle_budget", 64'(cyc), 64'(DEPTH - 1));
            end else begin
                chk("step",         64'(step),         64'(exp_step[cyc]));
                chk("stepfinished", 64'(stepfinished), 64'(exp_fin[cyc]));
                chk("moveind",      64'(moveind),      64'(exp_ind[cyc]));
                chk("move_done",    64'(move_done),    64'(exp_md[cyc]));
            end
        end
    end

    task automatic settle(input int from, input logic [3:0] fin, input logic [1:0] ind);
        for (int n = from; n < DEPTH; n++) begin
            exp_step[n] = 1'b0;
            exp_fin[n]  = fin;
            exp_ind[n]  = ind;
            exp_md[n]   = 1'b1;
        end
    endtask

    // Ticks land at l + k*div; a carry out of the position sum marks a pulse.
    task automatic predict(input int l, input int div, input int dur,
                           input logic [63:0] inc, input logic [63:0] incinc);
        logic [63:0] pos;
        logic [64:0] vel;
        logic [64:0] total_sum;
        int w;
        int t;
        pos = '0;
        vel = {1'b0, inc};
        w = (div / 2 < 1) ? 1 : div / 2;
        for (int k = 1; k <= dur; k++) begin
            t = l + k * div;
            if ($signed(vel) >= 0) begin
                total_sum = {1'b0, pos} + {1'b0, vel[63:0]};
                pos = total_sum[63:0];
                if (total_sum[64]) begin
                    for (int j = 0; j < w; j++) if (t + j < DEPTH) exp_step[t + j] = 1'b1;
                end
            end
            vel = vel + {incinc[63], incinc};
        end
    endtask

    task automatic launch(input int nmoves, input int div, input int dur,
                          input logic [63:0] inc, input logic [63:0] incinc,
                          output int a, output int c_last);
        int s;
        int l;
        int c;
        logic [3:0] mask;
        logic [1:0] slot;
        @(negedge CLK);
        a = cyc;
        clock_divisor      = 8'(div);
        move_duration      = 64'(dur);
        increment          = inc;
        incrementincrement = incinc;
        mask = '0;
        slot = mdl_ind;
        for (int i = 0; i < nmoves; i++) begin
            mask[slot] = 1'b1;
            slot = slot + 2'd1;
        end
        stepready = stepready ^ mask;
        s = a;
        for (int i = 0; i < nmoves; i++) begin
            l = s + 2;
            c = l + dur * div;
            predict(l, div, dur, inc, incinc);
            if (i > 0) for (int n = s; n < l; n++) exp_md[n] = 1'b0;
            for (int n = l; n < c; n++) exp_md[n] = 1'b0;
            for (int n = c; n < DEPTH; n++) begin
                exp_fin[n] = exp_fin[n] ^ (4'b0001 << mdl_ind);
                exp_ind[n] = mdl_ind + 2'd1;
            end
            mdl_fin = mdl_fin ^ (4'b0001 << mdl_ind);
            mdl_ind = mdl_ind + 2'd1;
            s = c;
        end
        c_last = s;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        check_en  = 1'b0;
        reset     = 1'b1;
        stepready = '0;
        halt      = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_step", 64'(step), 64'd0);
        chk("rst_fin",  64'(stepfinished), 64'd0);
        chk("rst_ind",  64'(moveind), 64'd0);
        chk("rst_md",   64'(move_done), 64'd1);
        reset   = 1'b0;
        mdl_fin = '0;
        mdl_ind = '0;
        settle(cyc, 4'd0, 2'd0);
        check_en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        int c;
        int base_r;
        int base_h;
        reset = 1'b1;
        halt = 1'b0;
        stepready = '0;
        writemoveind = '0;
        clock_divisor = 8'd4;
        move_duration = '0;
        increment = '0;
        incrementincrement = '0;
        do_reset();

        // Four queued moves back to back, wrapping the slot index.
        base_r = rises;
        launch(4, 2, 2, HALF, 64'd0, a, c);
        wait_until(c + 6);
        chk("queue_steps", 64'(rises - base_r), 64'd4);
        chk("queue_fin",   64'(stepfinished), 64'hF);
        chk("queue_ind",   64'(moveind), 64'd0);
        chk("queue_md",    64'(move_done), 64'd1);

        do_reset();

        // Half rate: a step every other tick, each two cycles wide.
        base_r = rises;
        base_h = hi_cnt;
        launch(1, 4, 8, HALF, 64'd0, a, c);
        wait_until(c + 6);
        chk("basic_steps",   64'(rises - base_r), 64'd4);
        chk("basic_width",   64'(hi_cnt - base_h), 64'd8);
        chk("basic_latency", 64'(fin_chg_cyc - a), 64'd34);
        chk("basic_fin",     64'(stepfinished), 64'h1);
        chk("basic_ind",     64'(moveind), 64'd1);
        chk("basic_md",      64'(move_done), 64'd1);

        // Quarter rate.
        base_r = rises;
        launch(1, 4, 8, QUARTER, 64'd0, a, c);
        wait_until(c + 6);
        chk("quarter_steps", 64'(rises - base_r), 64'd2);
        chk("quarter_fin",   64'(stepfinished), 64'h3);

        // Ramp from zero: position 21/16 of a step after tick 7.
        base_r = rises;
        launch(1, 2, 8, 64'd0, SIXTEENTH, a, c);
        wait_until(c + 6);
        chk("accel_steps", 64'(rises - base_r), 64'd1);
        chk("accel_when",  64'(rise_cyc - a), 64'd16);
        chk("accel_ind",   64'(moveind), 64'd3);

        // Zero-length move.
        base_r = rises;
        launch(1, 4, 0, HALF, 64'd0, a, c);
        wait_until(a + 8);
        chk("zero_latency", 64'(fin_chg_cyc - a), 64'd2);
        chk("zero_steps",   64'(rises - base_r), 64'd0);
        chk("zero_fin",     64'(stepfinished), 64'hF);
        chk("zero_ind",     64'(moveind), 64'd0);

        // Halt in the middle of the first of three queued moves.
        base_r = rises;
        launch(3, 4, 8, HALF, 64'd0, a, c);
        wait_until(a + 10);
        chk("halt_pre_step", 64'(step), 64'd1);
        halt = 1'b1;
        writemoveind = 2'd3;
        settle(a + 11, stepready, 2'd3);
        mdl_fin = stepready;
        mdl_ind = 2'd3;
        wait_until(a + 11);
        chk("halt_step", 64'(step), 64'd0);
        chk("halt_ind",  64'(moveind), 64'd3);
        wait_until(a + 13);
        halt = 1'b0;
        wait_until(a + 60);
        chk("halt_steps", 64'(rises - base_r), 64'd1);
        chk("halt_fin",   64'(stepfinished), 64'h8);
        chk("halt_md",    64'(move_done), 64'd1);

        // Asynchronous reset while a pulse is high.
        launch(1, 2, 8, HALF, 64'd0, a, c);
        wait_until(a + 6);
        chk("arst_pre_step", 64'(step), 64'd1);
        #2;
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_step", 64'(step), 64'd0);
        chk("arst_fin",  64'(stepfinished), 64'd0);
        chk("arst_ind",  64'(moveind), 64'd0);
        chk("arst_md",   64'(move_done), 64'd1);
        @(negedge CLK);
        reset = 1'b0;
        mdl_fin = '0;
        mdl_ind = '0;
        settle(cyc, 4'd0, 2'd0);
        check_en = 1'b1;
        repeat (10) @(negedge CLK);
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
